// File: rtl/mem_responder.sv
// Single-port data responder with wait states and write protection of the low program region,
// sharing its storage with a registered instruction-fetch port.
module mem_responder #(
    parameter int ADDR_SIZE = 12,
    parameter int WORD_SIZE = 16,
    parameter int WAIT_CYCLES = 1,
    parameter logic [ADDR_SIZE-1:0] PROT_TOP = 12'd64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    input  logic [ADDR_SIZE-1:0] rom_addr,
    output logic [WORD_SIZE-1:0] rom_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state;
    state_t state_next;

    logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_SIZE)-1];

    logic [3:0]           wait_cnt;
    logic                 lat_write;
    logic [ADDR_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_wdata;

    logic                 accept;
    logic                 do_access;
    logic                 do_write;
    logic                 acc_write;
    logic [ADDR_SIZE-1:0] acc_addr;
    logic [WORD_SIZE-1:0] acc_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With no wait states the access uses the live request fields, since they are only latched on this same edge.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        do_access  = 1'b0;
        acc_write  = lat_write;
        acc_addr   = lat_addr;
        acc_wdata  = lat_wdata;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                    end else begin
                        do_access  = 1'b1;
                        acc_write  = req_write;
                        acc_addr   = req_addr;
                        acc_wdata  = req_wdata;
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign do_write = do_access && acc_write && (acc_addr >= PROT_TOP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                wait_cnt  <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (do_access) begin
                if (!acc_write) begin
                    rsp_rdata <= mem[acc_addr];
                    rsp_err   <= 1'b0;
                end else if (acc_addr >= PROT_TOP) begin
                    rsp_rdata <= acc_wdata;
                    rsp_err   <= 1'b0;
                end else begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    // Storage is never cleared; the rst_n gate drops a write whose access edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_out <= '0;
        end else begin
            rom_out <= mem[rom_addr];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with a single wait state for the main scenarios,
// plus zero- and three-wait-state instances for latency.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_write;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic [11:0] rom_addr;

    logic        v1, rr1, ready1, valid1, err1;
    logic [15:0] rdata1, rom1;
    logic        v0, ready0, valid0, err0;
    logic [15:0] rdata0, rom0;
    logic        v3, ready3, valid3, err3;
    logic [15:0] rdata3, rom3;
    logic        alt_rr;

    int checks = 0;
    int passes = 0;
    int lat;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid1), .rsp_ready(rr1),
        .rsp_rdata(rdata1), .rsp_err(err1), .rom_addr(rom_addr), .rom_out(rom1)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid0), .rsp_ready(alt_rr),
        .rsp_rdata(rdata0), .rsp_err(err0), .rom_addr(rom_addr), .rom_out(rom0)
    );

    mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid3), .rsp_ready(alt_rr),
        .rsp_rdata(rdata3), .rsp_err(err3), .rom_addr(rom_addr), .rom_out(rom3)
    );

    function automatic logic validOf(input int inst);
        case (inst)
            0:       return valid0;
            1:       return valid1;
            default: return valid3;
        endcase
    endfunction

    function automatic logic readyOf(input int inst);
        case (inst)
            0:       return ready0;
            1:       return ready1;
            default: return ready3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int inst, input logic valid, input logic wr,
                                 input logic [11:0] addr, input logic [15:0] wdata);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        v0 = 1'b0;
        v1 = 1'b0;
        v3 = 1'b0;
        case (inst)
            0:       v0 = valid;
            1:       v1 = valid;
            default: v3 = valid;
        endcase
    endtask

    // Returns in the first cycle showing rsp_valid, with lat = cycles from the accept edge.
    task automatic runTxn(input int inst, input logic wr, input logic [11:0] addr,
                          input logic [15:0] wdata, output int latency);
        int guard;
        guard = 0;
        while (!readyOf(inst) && guard < 32) begin
            step();
            guard++;
        end
        applyStimulus(inst, 1'b1, wr, addr, wdata);
        step();
        applyStimulus(inst, 1'b0, wr, addr, wdata);
        latency = 1;
        while (!validOf(inst) && latency < 32) begin
            step();
            latency++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rr1      = 1'b1;
        alt_rr   = 1'b1;
        rom_addr = 12'h000;
        applyStimulus(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        u_w1.mem[12'h010] = 16'hA5A5;
        step();
        step();
        checkOutput("reset rsp_valid", 32'(valid1), 32'h0);
        checkOutput("reset rsp_rdata", 32'(rdata1), 32'h0);
        checkOutput("reset rsp_err", 32'(err1), 32'h0);
        checkOutput("reset rom_out", 32'(rom1), 32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("req_ready after release", 32'(ready1), 32'h1);

        runTxn(1, 1'b1, 12'h0C0, 16'hBEEF, lat);
        checkOutput("write 0C0 latency", 32'(lat), 32'd2);
        checkOutput("write 0C0 rdata", 32'(rdata1), 32'hBEEF);
        checkOutput("write 0C0 err", 32'(err1), 32'h0);

        runTxn(1, 1'b0, 12'h0C0, 16'h0000, lat);
        checkOutput("read 0C0 latency", 32'(lat), 32'd2);
        checkOutput("read 0C0 rdata", 32'(rdata1), 32'hBEEF);
        checkOutput("read 0C0 err", 32'(err1), 32'h0);

        runTxn(1, 1'b1, 12'h010, 16'h1234, lat);
        checkOutput("prot write err", 32'(err1), 32'h1);
        checkOutput("prot write rdata", 32'(rdata1), 32'h0);
        rom_addr = 12'h010;
        step();
        checkOutput("prot fetch unchanged", 32'(rom1), 32'hA5A5);

        rr1 = 1'b0;
        runTxn(1, 1'b0, 12'h0C0, 16'h0000, lat);
        applyStimulus(1, 1'b1, 1'b1, 12'h0C0, 16'hDEAD);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall rsp_valid", 32'(valid1), 32'h1);
            checkOutput("stall rsp_rdata", 32'(rdata1), 32'hBEEF);
            checkOutput("stall rsp_err", 32'(err1), 32'h0);
            checkOutput("stall req_ready", 32'(ready1), 32'h0);
            step();
        end
        applyStimulus(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        rr1 = 1'b1;
        checkOutput("stall still valid", 32'(valid1), 32'h1);
        step();
        checkOutput("idle after handshake valid", 32'(valid1), 32'h0);
        checkOutput("idle after handshake ready", 32'(ready1), 32'h1);
        runTxn(1, 1'b0, 12'h0C0, 16'h0000, lat);
        checkOutput("ignored write left 0C0", 32'(rdata1), 32'hBEEF);

        rom_addr = 12'h100;
        runTxn(1, 1'b1, 12'h100, 16'h0000, lat);
        runTxn(1, 1'b1, 12'h100, 16'h5555, lat);
        checkOutput("same-edge fetch old", 32'(rom1), 32'h0000);
        step();
        checkOutput("next fetch new", 32'(rom1), 32'h5555);

        runTxn(1, 1'b1, 12'h0C1, 16'h1111, lat);
        step();
        applyStimulus(1, 1'b1, 1'b1, 12'h0C1, 16'h2222);
        step();
        applyStimulus(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        rst_n = 1'b0;
        step();
        checkOutput("abort rsp_valid", 32'(valid1), 32'h0);
        checkOutput("abort rsp_rdata", 32'(rdata1), 32'h0);
        checkOutput("abort rsp_err", 32'(err1), 32'h0);
        checkOutput("abort rom_out", 32'(rom1), 32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("abort release ready", 32'(ready1), 32'h1);
        checkOutput("abort release valid", 32'(valid1), 32'h0);
        step();
        checkOutput("no late response", 32'(valid1), 32'h0);
        rom_addr = 12'h0C1;
        runTxn(1, 1'b0, 12'h0C1, 16'h0000, lat);
        checkOutput("aborted write read 0C1", 32'(rdata1), 32'h1111);
        checkOutput("aborted write fetch 0C1", 32'(rom1), 32'h1111);

        runTxn(0, 1'b1, 12'h200, 16'h7777, lat);
        checkOutput("w0 latency", 32'(lat), 32'd1);
        checkOutput("w0 rdata", 32'(rdata0), 32'h7777);
        checkOutput("w0 err", 32'(err0), 32'h0);
        runTxn(0, 1'b0, 12'h200, 16'h0000, lat);
        checkOutput("w0 read latency", 32'(lat), 32'd1);
        checkOutput("w0 read rdata", 32'(rdata0), 32'h7777);

        runTxn(3, 1'b1, 12'h200, 16'h3333, lat);
        checkOutput("w3 latency", 32'(lat), 32'd4);
        checkOutput("w3 rdata", 32'(rdata3), 32'h3333);
        runTxn(3, 1'b1, 12'h020, 16'h9999, lat);
        checkOutput("w3 prot latency", 32'(lat), 32'd4);
        checkOutput("w3 prot err", 32'(err3), 32'h1);
        checkOutput("w3 prot rdata", 32'(rdata3), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
